// File: rtl/rgb2bayer_mode0.sv
// rgb2bayer_mode0: re-mosaics a half-resolution {R,G,B} stream into a
// full-resolution Bayer stream. Each input pixel becomes a 2x2 quad, so each
// input line is written to one bank of an external ping-pong line buffer and
// then read back twice (even and odd output rows).
// Optional build macro: RGB2BAYER_TESTPAT_EN adds c_testpat, which replaces
// the Bayer sample with {out_row[0], out_col} for pipeline bring-up.
module rgb2bayer_mode0 #(
  parameter int PIXSIZE = 16,
  parameter int ROW_W   = 13,
  parameter int COL_W   = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c_en,
  input  logic [ROW_W:0]       c_rows,
  input  logic [COL_W:0]       c_cols,
  input  logic [1:0]           c_bayer_mode,
`ifdef RGB2BAYER_TESTPAT_EN
  input  logic                 c_testpat,
`endif
  input  logic                 frame_valid,
  input  logic                 line_valid,
  input  logic [3*PIXSIZE-1:0] pixel_data,
  output logic [COL_W-1:0]     waddr0,
  output logic [COL_W-1:0]     waddr1,
  output logic                 we0,
  output logic                 we1,
  output logic [3*PIXSIZE-1:0] din0,
  output logic [3*PIXSIZE-1:0] din1,
  output logic [COL_W-1:0]     raddr0,
  output logic [COL_W-1:0]     raddr1,
  input  logic [3*PIXSIZE-1:0] dout0,
  input  logic [3*PIXSIZE-1:0] dout1,
  output logic                 frame_valid_o,
  output logic                 line_valid_o,
  output logic [PIXSIZE-1:0]   pixel_data_o,
  output logic                 frame_start_o,
  output logic                 line_start_o,
  output logic                 overrun_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ROW_E = 3'd1,
    GAP   = 3'd2,
    ROW_O = 3'd3,
    GAP2  = 3'd4
  } state_t;

  // Only the test pattern needs the full column number downstream.
`ifdef RGB2BAYER_TESTPAT_EN
  localparam int TPC_W = COL_W + 1;
`else
  localparam int TPC_W = 1;
`endif

  // Pick the Bayer component for a (row parity, column parity) site.
  // Green sits where the parities differ unless mode[0] flips the lattice;
  // mode[1] decides whether red or blue occupies the even row.
  function automatic logic [PIXSIZE-1:0] cfa_pick(input logic [3*PIXSIZE-1:0] rgb,
                                                  input logic [1:0] mode,
                                                  input logic rp, input logic cp);
    logic [PIXSIZE-1:0] pick;
    if ((rp ^ cp) != mode[0]) pick = rgb[2*PIXSIZE-1 -: PIXSIZE];
    else if (rp ^ mode[1])     pick = rgb[3*PIXSIZE-1 -: PIXSIZE];
    else                       pick = rgb[PIXSIZE-1:0];
    return pick;
  endfunction

`ifdef RGB2BAYER_TESTPAT_EN
  function automatic logic [PIXSIZE-1:0] testpat_value(input logic row0, input logic [COL_W:0] col);
    logic [COL_W+1:0] tp;
    tp = {row0, col};
    return PIXSIZE'(tp);
  endfunction
`endif

  logic [ROW_W:0]   rows_cfg;
  logic [COL_W:0]   cols_cfg;
  logic [COL_W-1:0] in_col;
  logic [ROW_W-1:0] in_row;
  logic             accept, in_col_last, in_row_last, complete, wbank;
  logic [1:0]       full, full_kept, full_nx;
  logic             older, oldest;
  state_t           state, state_nx;
  logic [COL_W:0]   out_col, out_col_nx;
  logic [ROW_W:0]   out_row, out_row_nx;
  logic             rd_bank, rd_bank_nx, rowing, rel_bank, out_col_last, out_row_last;
  logic             s1_valid, s1_first, s1_ls, s1_last, s1_bank, s1_row0;
  logic             s2_valid, s2_first, s2_ls, s2_last, s2_bank, s2_row0;
  logic [TPC_W-1:0] s1_col, s2_col;
  logic [1:0]       s1_mode, s2_mode;
  logic             last_o;
  logic [3*PIXSIZE-1:0] rd_data;
  logic [PIXSIZE-1:0]   sample;

  assign accept       = c_en & frame_valid & line_valid;
  assign in_col_last  = (in_col == (cols_cfg[COL_W:1] - COL_W'(1'b1)));
  assign in_row_last  = (in_row == (rows_cfg[ROW_W:1] - ROW_W'(1'b1)));
  assign complete     = accept & in_col_last;
  assign wbank        = in_row[0];
  assign out_col_last = (out_col == (cols_cfg - (COL_W+1)'(1'b1)));
  assign out_row_last = (out_row == (rows_cfg - (ROW_W+1)'(1'b1)));
  assign oldest       = (full[0] & full[1]) ? older : full[1];

  // Capture frame geometry while the block is disabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rows_cfg <= '0;
      cols_cfg <= '0;
    end else if (!c_en) begin
      rows_cfg <= c_rows;
      cols_cfg <= c_cols;
    end
  end

  // Write side: count input pixels and issue one registered RAM write each.
  always_ff @(posedge clk) begin
    if (!rst_n || !c_en) begin
      in_col <= '0;
      in_row <= '0;
      we0    <= 1'b0;
      we1    <= 1'b0;
      waddr0 <= '0;
      waddr1 <= '0;
      din0   <= '0;
      din1   <= '0;
    end else begin
      we0 <= accept & ~wbank;
      we1 <= accept & wbank;
      if (accept) begin
        waddr0 <= in_col;
        waddr1 <= in_col;
        din0   <= pixel_data;
        din1   <= pixel_data;
        if (in_col_last) begin
          in_col <= '0;
          in_row <= in_row_last ? '0 : in_row + ROW_W'(1'b1);
        end else begin
          in_col <= in_col + COL_W'(1'b1);
        end
      end
    end
  end

  // Bank full flags: a read release is applied before a same-cycle fill.
  always_comb begin
    full_kept = full;
    if (rel_bank) full_kept[rd_bank] = 1'b0;
    else          full_kept = full;
    full_nx = full_kept;
    if (complete) full_nx[wbank] = 1'b1;
    else          full_nx = full_kept;
  end

  // Full flags, fill order and sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n || !c_en) begin
      full      <= 2'b00;
      older     <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      full <= full_nx;
      if (complete) begin
        older <= full_kept[~wbank] ? ~wbank : wbank;
        if (full_kept[wbank]) overrun_o <= 1'b1;
      end
    end
  end

  // Read FSM state and output raster position registers.
  always_ff @(posedge clk) begin
    if (!rst_n || !c_en) begin
      state   <= IDLE;
      out_col <= '0;
      out_row <= '0;
      rd_bank <= 1'b0;
    end else begin
      state   <= state_nx;
      out_col <= out_col_nx;
      out_row <= out_row_nx;
      rd_bank <= rd_bank_nx;
    end
  end

  // Read FSM next state: each buffered line is read twice with gaps between.
  always_comb begin
    state_nx   = state;
    out_col_nx = out_col;
    out_row_nx = out_row;
    rd_bank_nx = rd_bank;
    rowing     = 1'b0;
    rel_bank   = 1'b0;
    case (state)
      IDLE: begin
        if (full[0] | full[1]) begin
          state_nx   = ROW_E;
          rd_bank_nx = oldest;
        end else begin
          state_nx = IDLE;
        end
      end
      ROW_E, ROW_O: begin
        rowing = 1'b1;
        if (out_col_last) begin
          out_col_nx = '0;
          out_row_nx = out_row_last ? '0 : out_row + (ROW_W+1)'(1'b1);
          state_nx   = (state == ROW_E) ? GAP : GAP2;
          rel_bank   = (state == ROW_O);
        end else begin
          out_col_nx = out_col + (COL_W+1)'(1'b1);
        end
      end
      GAP: state_nx = ROW_O;
      GAP2: begin
        if (full[~rd_bank]) begin
          state_nx   = ROW_E;
          rd_bank_nx = ~rd_bank;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pipeline stages 1 (RAM address) and 2 (RAM data) carry the site info.
  always_ff @(posedge clk) begin
    if (!rst_n || !c_en) begin
      raddr0 <= '0;  raddr1 <= '0;
      s1_valid <= 1'b0; s1_first <= 1'b0; s1_ls <= 1'b0; s1_last <= 1'b0;
      s1_bank <= 1'b0;  s1_row0 <= 1'b0;  s1_col <= '0;  s1_mode <= 2'b00;
      s2_valid <= 1'b0; s2_first <= 1'b0; s2_ls <= 1'b0; s2_last <= 1'b0;
      s2_bank <= 1'b0;  s2_row0 <= 1'b0;  s2_col <= '0;  s2_mode <= 2'b00;
    end else begin
      if (rowing) begin
        raddr0 <= out_col[COL_W:1];
        raddr1 <= out_col[COL_W:1];
      end
      s1_valid <= rowing;
      s1_first <= rowing & (out_col == '0) & (out_row == '0);
      s1_ls    <= rowing & (out_col == '0);
      s1_last  <= rowing & out_col_last & out_row_last;
      s1_bank  <= rd_bank;
      s1_row0  <= out_row[0];
      s1_col   <= out_col[TPC_W-1:0];
      if (rowing && (out_col == '0)) s1_mode <= c_bayer_mode;
      s2_valid <= s1_valid; s2_first <= s1_first; s2_ls <= s1_ls; s2_last <= s1_last;
      s2_bank  <= s1_bank;  s2_row0  <= s1_row0;  s2_col <= s1_col; s2_mode <= s1_mode;
    end
  end

  assign rd_data = s2_bank ? dout1 : dout0;

  // Select the outgoing sample from the read word (or the test pattern).
  always_comb begin
`ifdef RGB2BAYER_TESTPAT_EN
    if (c_testpat) sample = testpat_value(s2_row0, s2_col);
    else           sample = cfa_pick(rd_data, s2_mode, s2_row0, s2_col[0]);
`else
    sample = cfa_pick(rd_data, s2_mode, s2_row0, s2_col[0]);
`endif
  end

  // Output register stage and frame qualifier.
  always_ff @(posedge clk) begin
    if (!rst_n || !c_en) begin
      line_valid_o  <= 1'b0;
      frame_start_o <= 1'b0;
      line_start_o  <= 1'b0;
      frame_valid_o <= 1'b0;
      pixel_data_o  <= '0;
      last_o        <= 1'b0;
    end else begin
      line_valid_o  <= s2_valid;
      frame_start_o <= s2_first;
      line_start_o  <= s2_ls;
      last_o        <= s2_last;
      pixel_data_o  <= s2_valid ? sample : '0;
      if (s2_first)    frame_valid_o <= 1'b1;
      else if (last_o) frame_valid_o <= 1'b0;
    end
  end

endmodule
